// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: round-robin sharing of one toggle-enabled USART transmitter among NUM_REQ byte sources
module usart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 16384,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_response,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 done,
  output logic                 timeout_err
);
  localparam int WDW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDW:0] NR = NUM_REQ[IDW:0];
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CLKS - 1);
  localparam logic [WDW-1:0] WD_SAT = WDW'(TIMEOUT_CLKS);
  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;
  state_t state;
  logic [IDW-1:0] last_grant, win;
  logic [IDW:0] j;
  logic [WDW-1:0] wd;
  assign busy = state != IDLE;
  // descending scan so the smallest offset after last_grant wins
  always_comb begin
    win = last_grant;
    j = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = {1'b0, last_grant} + (IDW+1)'(i);
      j = (j >= NR) ? j - NR : j;
      win = req_valid[j[IDW-1:0]] ? j[IDW-1:0] : win;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_ready   <= '0;
      tx_data     <= '0;
      tx_enable   <= 1'b0;
      grant_id    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= IDW'(NUM_REQ - 1);
      wd          <= '0;
    end else begin
      req_ready   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          req_ready  <= NUM_REQ'(1) << win;
          tx_data    <= req_data[{win, 3'b000} +: 8];
          grant_id   <= win;
          last_grant <= win;
          state      <= LOAD;
        end
        LOAD: begin
          tx_enable <= ~tx_enable;
          wd        <= '0;
          state     <= BUSY;
        end
        BUSY: begin
          wd <= (wd == WD_SAT) ? wd : wd + 1'b1;
          if (tx_response) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (wd == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb_usart_tx_arbiter: directed and randomized frames checked against a round-robin reference model
module tb_usart_tx_arbiter;
  logic clk = 1'b0, reset = 1'b0, tx_response = 1'b0;
  logic [3:0] req_valid = '0, req_ready;
  logic [31:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_enable, busy, done, timeout_err;
  logic [1:0] grant_id;
  int vectors = 0, miscompares = 0;
  int m_last = 3;
  logic m_tog = 1'b0;
  logic [7:0] bytes [4];

  usart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CLKS(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_enable(tx_enable),
    .tx_response(tx_response), .busy(busy), .grant_id(grant_id),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [3:0] v, input int last);
    for (int i = 1; i <= 4; i++)
      if (v[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  task automatic do_reset;
    reset = 1'b0;
    tx_response = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    m_last = 3;
    m_tog = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_txen"}, tx_enable, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_txd"}, tx_data, 0);
  endtask

  // delay = cycles after the toggle until tx_response; above 64 the watchdog fires instead
  task automatic frame(input string tag, input logic [3:0] v, input int delay);
    int w, n, lim;
    req_valid = v;
    req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    w = rr(v, m_last);
    n = 0;
    do begin
      tick;
      n++;
    end while (req_ready == 0 && n < 4);
    chk({tag, "_ready"}, req_ready, 32'd1 << w);
    chk({tag, "_txd"}, tx_data, bytes[w]);
    chk({tag, "_gid"}, grant_id, w);
    chk({tag, "_txen_pre"}, tx_enable, m_tog);
    m_last = w;
    m_tog = ~m_tog;
    tick;
    chk({tag, "_txen"}, tx_enable, m_tog);
    chk({tag, "_ready_off"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 1);
    lim = delay > 64 ? 64 : delay;
    for (int k = 1; k < lim; k++) begin
      tick;
      chk({tag, "_early"}, {done, timeout_err}, 0);
    end
    tx_response = delay <= 64;
    tick;
    tx_response = 1'b0;
    chk({tag, "_done"}, done, delay <= 64);
    chk({tag, "_tmo"}, timeout_err, delay > 64);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, {tx_enable, grant_id, tx_data}, {m_tog, 2'(w), bytes[w]});
  endtask

  initial begin
    bytes = '{8'hA5, 8'h00, 8'h00, 8'h00};
    tick;
    idle_outputs("rst");
    do_reset;
    idle_outputs("rst2");
    frame("t1", 4'b0001, 20);
    req_valid = '0;
    do_reset;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 5; i++) frame("t2", 4'b1111, 3 + i);
    frame("t2b", 4'b1111, 5);
    frame("t2c", 4'b1111, 5);
    frame("t3a", 4'b1010, 4);
    frame("t3b", 4'b1010, 4);
    frame("t4", 4'b0100, 100);
    frame("t4b", 4'b1000, 6);
    frame("t5", 4'b0001, 64);
    req_valid = '0;
    tx_response = 1'b1;
    tick;
    tx_response = 1'b0;
    chk("stray_done", done, 0);
    chk("stray_busy", busy, 0);
    tick;
    chk("stray_ready", req_ready, 0);
    req_valid = 4'b0100;
    tick;
    tick;
    tick;
    tick;
    chk("t6_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    idle_outputs("t6");
    tick;
    reset = 1'b1;
    m_last = 3;
    m_tog = 1'b0;
    frame("t6r", 4'b1111, 8);
    for (int i = 0; i < 30; i++) begin
      for (int b = 0; b < 4; b++) bytes[b] = 8'($urandom);
      frame("rnd", 4'($urandom_range(1, 15)), $urandom_range(1, 70));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
